cpu6502_dma_arbiter: RTL and testbench

- Bus arbiter and sequencer that shares the Cpu6502 external bus with a page-copy DMA engine (sprite-DMA style).
- Sits between Cpu6502 and the system bus. On a DMA request it stalls the CPU by gating its clock enable, takes the bus, and copies 256 bytes from page {dmaPage,00..FF} to a fixed destination address.
- It then returns the bus to the CPU.
- The CPU can only be stalled on read cycles. Transfers are aligned to an even/odd cycle parity.

---
 rtl/cpu6502_dma_pkg.sv | 26 ++
 rtl/cpu6502_dma_arbiter.sv | 140 ++++++++++++++
 tb/tb_cpu6502_dma_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu6502_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu6502_dma_pkg
//  Description : Shared types and constants for the Cpu6502 page-copy DMA
//                arbiter (sequencer states, transfer length, default target).
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu6502_dma_pkg;

    // Sequencer states of the DMA arbiter
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_READ = 3'd1,
        ALIGN     = 3'd2,
        READ      = 3'd3,
        WRITE     = 3'd4
    } dmaState_t;

    // Bytes moved per request: one full source page
    localparam int DMA_LENGTH = 256;

    // Write address used for every DMA write cycle unless overridden
    localparam logic [15:0] DEFAULT_DEST_ADDR = 16'h2004;

endpackage : cpu6502_dma_pkg
`default_nettype wire

// File: rtl/cpu6502_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cpu6502_dma_arbiter
//  Description : Shares the Cpu6502 external bus with a sprite-style page
//                copy engine. A request stalls the CPU on its next read
//                cycle, optionally aligns to even parity, copies 256 bytes
//                from {page,00..FF} to a fixed address, then hands the bus
//                back to the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu6502_dma_arbiter
    import cpu6502_dma_pkg::*;
#(
    parameter logic [15:0] DEST_ADDR    = DEFAULT_DEST_ADDR,
    parameter int unsigned ALIGN_ENABLE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        dmaStart,
    input  logic [7:0]  dmaPage,
    input  logic [15:0] cpuAddress,
    input  logic [7:0]  cpuDataOut,
    input  logic        cpuNWrite,
    output logic        cpuEnable,
    output logic [15:0] address,
    output logic [7:0]  dataOut,
    output logic        nWrite,
    input  logic [7:0]  dataIn,
    output logic        busy,
    output logic        done
);

    // Counter value of the final byte of the page
    localparam logic [7:0] c_LAST_BYTE = 8'(DMA_LENGTH - 1);

    dmaState_t   r_state;
    logic        r_parity;
    logic [7:0]  r_counter;
    logic [7:0]  r_dataLatch;
    logic [7:0]  r_pageLatch;
    logic        r_busy;
    logic        r_done;

    // Sequencer: advances only on enabled cycles; busy/done registered here
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_parity    <= 1'b0;
            r_counter   <= 8'h00;
            r_dataLatch <= 8'h00;
            r_pageLatch <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (enable) begin
            r_parity <= ~r_parity;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (dmaStart) begin
                        r_pageLatch <= dmaPage;
                        r_counter   <= 8'h00;
                        r_busy      <= 1'b1;
                        r_state     <= WAIT_READ;
                    end
                end
                WAIT_READ: begin
                    // A CPU write keeps us waiting; the first read is the halt cycle
                    if (cpuNWrite) begin
                        if ((ALIGN_ENABLE != 0) && !r_parity) begin
                            r_state <= ALIGN;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end
                ALIGN: begin
                    r_state <= READ;
                end
                READ: begin
                    r_dataLatch <= dataIn;
                    r_state     <= WRITE;
                end
                WRITE: begin
                    r_counter <= r_counter + 8'd1;
                    if (r_counter == c_LAST_BYTE) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= READ;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Bus mux and CPU clock gate; reset releases the CPU in the same cycle
    always_comb begin
        address   = cpuAddress;
        dataOut   = cpuDataOut;
        nWrite    = cpuNWrite;
        cpuEnable = enable;
        if (!reset) begin
            case (r_state)
                WAIT_READ: begin
                    if (cpuNWrite) begin
                        cpuEnable = 1'b0;
                    end
                end
                ALIGN: begin
                    cpuEnable = 1'b0;
                    nWrite    = 1'b1;
                end
                READ: begin
                    cpuEnable = 1'b0;
                    address   = {r_pageLatch, r_counter};
                    nWrite    = 1'b1;
                end
                WRITE: begin
                    cpuEnable = 1'b0;
                    address   = DEST_ADDR;
                    dataOut   = r_dataLatch;
                    nWrite    = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule : cpu6502_dma_arbiter
`default_nettype wire

// File: tb/tb_cpu6502_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu6502_dma_arbiter
//  Description : Directed bench for cpu6502_dma_arbiter. Two instances share
//                the stimulus: one with alignment, one without.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu6502_dma_arbiter;

    localparam logic [15:0] c_DEST = 16'h2004;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        dmaStart;
    logic [7:0]  dmaPage;
    logic [15:0] cpuAddress;
    logic [7:0]  cpuDataOut;
    logic        cpuNWrite;

    logic        cpuEnableA, nWriteA, busyA, doneA;
    logic [15:0] addressA;
    logic [7:0]  dataOutA, dataInA;
    logic        cpuEnableB, nWriteB, busyB, doneB;
    logic [15:0] addressB;
    logic [7:0]  dataOutB, dataInB;

    int checks = 0;
    int errors = 0;
    bit tbParity = 1'b0;

    // Source memory contents as a function of address
    function automatic logic [7:0] srcByte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign dataInA = srcByte(addressA);
    assign dataInB = srcByte(addressB);

    always #5 clock = ~clock;

    cpu6502_dma_arbiter #(.DEST_ADDR(c_DEST), .ALIGN_ENABLE(1)) dutA (
        .clock(clock), .reset(reset), .enable(enable), .dmaStart(dmaStart),
        .dmaPage(dmaPage), .cpuAddress(cpuAddress), .cpuDataOut(cpuDataOut),
        .cpuNWrite(cpuNWrite), .cpuEnable(cpuEnableA), .address(addressA),
        .dataOut(dataOutA), .nWrite(nWriteA), .dataIn(dataInA),
        .busy(busyA), .done(doneA)
    );

    cpu6502_dma_arbiter #(.DEST_ADDR(c_DEST), .ALIGN_ENABLE(0)) dutB (
        .clock(clock), .reset(reset), .enable(enable), .dmaStart(dmaStart),
        .dmaPage(dmaPage), .cpuAddress(cpuAddress), .cpuDataOut(cpuDataOut),
        .cpuNWrite(cpuNWrite), .cpuEnable(cpuEnableB), .address(addressB),
        .dataOut(dataOutB), .nWrite(nWriteB), .dataIn(dataInB),
        .busy(busyB), .done(doneB)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; parity model follows the inputs present at the edge
    task automatic stepClock();
        @(posedge clock);
        if (reset) tbParity = 1'b0;
        else if (enable) tbParity = ~tbParity;
        #1;
    endtask

    // Tally one enabled cycle of bus activity for one instance
    task automatic observe(input logic [15:0] addr, input logic [7:0] dout,
                           input logic nw, input logic cen, input logic dn,
                           input logic bsy, input logic [7:0] page,
                           inout int halted, inout int reads, inout int writes,
                           inout int bad, inout int dones, inout int busyAtDone);
        if (!cen) halted++;
        if (!cen && nw && addr[15:8] == page) begin
            if (addr[7:0] != 8'(reads)) bad++;
            reads++;
        end
        if (!cen && !nw) begin
            if (addr != c_DEST || dout != srcByte({page, 8'(writes)})) bad++;
            writes++;
        end
        if (dn) begin
            dones++;
            if (bsy) busyAtDone++;
        end
    endtask

    // Idle cycle if needed so the halt cycle sees the wanted parity
    task automatic alignParity(input bit want, input int preWrites);
        enable = 1'b1; dmaStart = 1'b0; cpuNWrite = 1'b1; cpuAddress = 16'hC123;
        if ((tbParity ^ 1'((preWrites + 1) % 2)) != want) stepClock();
    endtask

    task automatic runTransfer(input string tag, input logic [7:0] page,
                               input int preWrites, input bit toggleEn,
                               input int restartAt, input int resetAt);
        int cyc = 0, k = 0, tail = 0;
        bit finished = 1'b0, didReset = 1'b0, parityAtHalt = 1'b0;
        int haltedA = 0, readsA = 0, writesA = 0, badA = 0, donesA = 0, bdA = 0;
        int haltedB = 0, readsB = 0, writesB = 0, badB = 0, donesB = 0, bdB = 0;
        int stalls = 0, cenOff = 0, tailDones = 0;
        while (!finished && cyc < 3000) begin
            enable     = toggleEn ? (cyc % 2 == 0) : 1'b1;
            dmaStart   = enable && (k == 0 || k == restartAt);
            dmaPage    = (k == restartAt) ? 8'hEE : page;
            if (enable) cpuNWrite = (k >= 1 && k <= preWrites) ? 1'b0 : 1'b1;
            cpuAddress = cpuNWrite ? 16'hC123 : 16'h01FD;
            cpuDataOut = 8'h77;
            #1;
            if (!enable) begin
                if (cpuEnableA || cpuEnableB) cenOff++;
            end else begin
                if (k >= 1 && k <= preWrites && (!cpuEnableA || !cpuEnableB)) stalls++;
                if (k == 0) check({tag, "/busyBeforeStart"}, int'(busyA), 0);
                if (k == 1) check({tag, "/busyAfterStart"}, int'(busyA), 1);
                if (k == preWrites + 1) begin
                    parityAtHalt = tbParity;
                    check({tag, "/haltCycleA"}, int'(cpuEnableA), 0);
                    check({tag, "/haltCycleB"}, int'(cpuEnableB), 0);
                end
                observe(addressA, dataOutA, nWriteA, cpuEnableA, doneA, busyA, page,
                        haltedA, readsA, writesA, badA, donesA, bdA);
                observe(addressB, dataOutB, nWriteB, cpuEnableB, doneB, busyB, page,
                        haltedB, readsB, writesB, badB, donesB, bdB);
                if (donesA > 0 && donesB > 0) begin
                    tail++;
                    if (tail >= 3) finished = 1'b1;
                end
                if (resetAt > 0 && writesA == resetAt) begin
                    stepClock();
                    reset = 1'b1; dmaStart = 1'b0; enable = 1'b1;
                    #1;
                    check({tag, "/cpuEnableInReset"}, int'(cpuEnableA), 1);
                    stepClock();
                    reset = 1'b0;
                    #1;
                    check({tag, "/busyAfterReset"}, int'(busyA), 0);
                    check({tag, "/doneAfterReset"}, int'(doneA), 0);
                    check({tag, "/cpuEnableAfterReset"}, int'(cpuEnableA), 1);
                    check({tag, "/mirrorAfterReset"}, int'(addressA), int'(cpuAddress));
                    for (int i = 0; i < 4; i++) begin
                        stepClock();
                        #1;
                        if (doneA || doneB || busyA) tailDones++;
                    end
                    didReset = 1'b1;
                    finished = 1'b1;
                end
            end
            if (!finished) begin
                if (enable) k++;
                cyc++;
                stepClock();
            end
        end
        check({tag, "/finished"}, int'(finished), 1);
        if (resetAt > 0) begin
            check({tag, "/didReset"}, int'(didReset), 1);
            check({tag, "/noDoneOnReset"}, donesA + tailDones, 0);
        end else begin
            check({tag, "/haltedA"}, haltedA, parityAtHalt ? 513 : 514);
            check({tag, "/haltedB"}, haltedB, 513);
            check({tag, "/readsA"}, readsA, 256);
            check({tag, "/writesA"}, writesA, 256);
            check({tag, "/readsB"}, readsB, 256);
            check({tag, "/writesB"}, writesB, 256);
            check({tag, "/badBusA"}, badA, 0);
            check({tag, "/badBusB"}, badB, 0);
            check({tag, "/donePulsesA"}, donesA, 1);
            check({tag, "/donePulsesB"}, donesB, 1);
            check({tag, "/busyWithDone"}, bdA + bdB, 0);
            check({tag, "/writeStalls"}, stalls, 0);
            check({tag, "/cenWhileDisabled"}, cenOff, 0);
            check({tag, "/busyEnd"}, int'(busyA | busyB), 0);
            check({tag, "/releasedEnd"}, int'(cpuEnableA & cpuEnableB), 1);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; dmaStart = 1'b0; dmaPage = 8'h00;
        cpuAddress = 16'h1234; cpuDataOut = 8'hA5; cpuNWrite = 1'b1;
        stepClock();
        stepClock();
        check("resetBusy", int'(busyA), 0);
        check("resetDone", int'(doneA), 0);
        check("resetCpuEnable", int'(cpuEnableA), 1);
        check("resetAddrMirror", int'(addressA), 16'h1234);
        check("resetDataMirror", int'(dataOutA), 8'hA5);
        reset = 1'b0;
        stepClock();
        enable = 1'b0; cpuNWrite = 1'b0;
        #1;
        check("idleDisabledCpuEnable", int'(cpuEnableA), 0);
        check("idleWriteMirror", int'(nWriteA), 0);
        stepClock();

        alignParity(1'b1, 0);
        runTransfer("parity1", 8'h02, 0, 1'b0, -1, 0);
        alignParity(1'b0, 0);
        runTransfer("parity0", 8'h02, 0, 1'b0, -1, 0);
        alignParity(1'b0, 3);
        runTransfer("push3", 8'h03, 3, 1'b0, -1, 0);
        alignParity(1'b1, 1);
        runTransfer("toggle", 8'h05, 1, 1'b1, -1, 0);
        alignParity(1'b0, 0);
        runTransfer("restart", 8'h06, 0, 1'b0, 300, 0);
        alignParity(1'b1, 0);
        runTransfer("reset", 8'h40, 0, 1'b0, -1, 100);
        alignParity(1'b0, 0);
        runTransfer("afterReset", 8'h41, 0, 1'b0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cpu6502_dma_arbiter
`default_nettype wire
